// File: rtl/updi_instruction_decoder_pkg.sv
// Shared UPDI definitions: instruction enum, opcode bit positions, frame constants
// and the decoded-field record passed from the operand counter to the decoder FSM.
package updi_instruction_decoder_pkg;

  typedef enum logic [2:0] {
    UPDI_LDS    = 3'd0,
    UPDI_LD     = 3'd1,
    UPDI_STS    = 3'd2,
    UPDI_ST     = 3'd3,
    UPDI_LDCS   = 3'd4,
    UPDI_REPEAT = 3'd5,
    UPDI_STCS   = 3'd6,
    UPDI_KEY    = 3'd7
  } updi_instruction;

  localparam int UPDI_INSN_MSB   = 7;
  localparam int UPDI_INSN_LSB   = 5;
  localparam int UPDI_RSVD_BIT   = 4;
  localparam int UPDI_FIELD1_MSB = 3;
  localparam int UPDI_FIELD1_LSB = 2;
  localparam int UPDI_FIELD0_MSB = 1;
  localparam int UPDI_FIELD0_LSB = 0;
  localparam int UPDI_SIB_BIT    = 2;

  localparam logic [7:0] UPDI_SYNCH       = 8'h55;
  localparam logic [4:0] UPDI_KEY_LEN_64  = 5'd8;
  localparam logic [4:0] UPDI_KEY_LEN_128 = 5'd16;

  typedef struct packed {
    updi_instruction instr;
    logic [1:0]      size_a;
    logic [1:0]      size_b;
    logic [1:0]      ptr;
    logic [3:0]      cs_addr;
    logic            sib;
    logic [1:0]      size_c;
  } updi_fields_t;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_OPCODE  = 2'd1,
    ST_OPERAND = 2'd2
  } dec_state_e;

  // Byte count of an address/data size code (0 -> 1 byte, 1 -> 2, 2 -> 3).
  function automatic logic [4:0] size_len(input logic [1:0] s);
    return {3'b000, s} + 5'd1;
  endfunction

endpackage

// File: rtl/updi_instruction_decoder_operand_counter.sv
// Combinational opcode decode: splits the opcode into fields, checks legality and
// derives how many operand bytes the frame carries.
module updi_operand_counter
  import updi_instruction_decoder_pkg::*;
(
  input  logic [7:0]   opcode_i,
  output updi_fields_t fields_o,
  output logic [4:0]   count_o,
  output logic         legal_o
);

  updi_fields_t f;
  logic [4:0]   cnt;
  logic         legal;

  always_comb begin
    f       = '0;
    f.instr = updi_instruction'(opcode_i[UPDI_INSN_MSB:UPDI_INSN_LSB]);
    case (f.instr)
      UPDI_LDS, UPDI_STS: begin
        f.size_a = opcode_i[UPDI_FIELD1_MSB:UPDI_FIELD1_LSB];
        f.size_b = opcode_i[UPDI_FIELD0_MSB:UPDI_FIELD0_LSB];
      end
      UPDI_LD, UPDI_ST: begin
        f.ptr    = opcode_i[UPDI_FIELD1_MSB:UPDI_FIELD1_LSB];
        f.size_a = opcode_i[UPDI_FIELD0_MSB:UPDI_FIELD0_LSB];
        f.size_b = opcode_i[UPDI_FIELD0_MSB:UPDI_FIELD0_LSB];
      end
      UPDI_LDCS, UPDI_STCS: f.cs_addr = opcode_i[3:0];
      UPDI_REPEAT: f.size_b = opcode_i[UPDI_FIELD0_MSB:UPDI_FIELD0_LSB];
      UPDI_KEY: begin
        f.sib    = opcode_i[UPDI_SIB_BIT];
        f.size_c = opcode_i[UPDI_FIELD0_MSB:UPDI_FIELD0_LSB];
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt = 5'd0;
    case (f.instr)
      UPDI_LDS:    cnt = size_len(f.size_a);
      UPDI_STS:    cnt = size_len(f.size_a) + size_len(f.size_b);
      UPDI_ST:     cnt = (f.ptr == 2'd2) ? size_len(f.size_a) : size_len(f.size_b);
      UPDI_STCS:   cnt = 5'd1;
      UPDI_REPEAT: cnt = size_len(f.size_b);
      UPDI_KEY:    if (!f.sib) cnt = f.size_c[0] ? UPDI_KEY_LEN_128 : UPDI_KEY_LEN_64;
      default:     cnt = 5'd0;
    endcase
  end

  // Fields not used by an instruction decode as 0, so the range checks apply globally.
  always_comb begin
    legal = 1'b1;
    if (opcode_i[UPDI_RSVD_BIT] && f.instr != UPDI_LDCS && f.instr != UPDI_STCS) legal = 1'b0;
    if (f.instr == UPDI_REPEAT && (opcode_i[4:2] != 3'b000 || f.size_b > 2'd1)) legal = 1'b0;
    if (f.instr == UPDI_KEY && opcode_i[4:3] != 2'b00) legal = 1'b0;
    if (f.size_a == 2'd3 || f.size_b == 2'd3 || f.ptr == 2'd3) legal = 1'b0;
    if (f.size_c > 2'd1) legal = 1'b0;
  end

  assign fields_o = f;
  assign count_o  = cnt;
  assign legal_o  = legal;

endmodule

// File: rtl/updi_instruction_decoder.sv
// Target-side UPDI frame parser: SYNCH / opcode / operand FSM with registered
// field outputs, operand tagging and single-cycle status pulses.
module updi_instruction_decoder
  import updi_instruction_decoder_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output updi_instruction instruction,
  output logic [1:0]      size_a,
  output logic [1:0]      size_b,
  output logic [1:0]      ptr,
  output logic [3:0]      cs_addr,
  output logic            sib,
  output logic [1:0]      size_c,
  output logic            opcode_valid,
  output logic [7:0]      operand_data,
  output logic            operand_valid,
  output logic [4:0]      operand_index,
  output logic            done,
  output logic            err
);

  dec_state_e   state_q, state_d;
  updi_fields_t fields_q, fields_d;
  logic [4:0]   rem_q, rem_d;
  logic [4:0]   nxt_q, nxt_d;
  logic [4:0]   idx_q, idx_d;
  logic [7:0]   data_q, data_d;
  logic         opv_q, opv_d;
  logic         ov_q, ov_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  updi_fields_t dec_fields;
  logic [4:0]   dec_count;
  logic         dec_legal;

  updi_operand_counter u_cnt (
    .opcode_i (in_data),
    .fields_o (dec_fields),
    .count_o  (dec_count),
    .legal_o  (dec_legal)
  );

  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    rem_d    = rem_q;
    nxt_d    = nxt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    opv_d    = 1'b0;
    ov_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (abort) begin
      state_d = ST_SYNC;
    end else if (in_valid) begin
      case (state_q)
        ST_SYNC: begin
          if (in_data == UPDI_SYNCH) state_d = ST_OPCODE;
          else err_d = 1'b1;
        end
        ST_OPCODE: begin
          if (!dec_legal) begin
            err_d   = 1'b1;
            state_d = ST_SYNC;
          end else begin
            fields_d = dec_fields;
            opv_d    = 1'b1;
            rem_d    = dec_count;
            nxt_d    = 5'd0;
            if (dec_count == 5'd0) begin
              done_d  = 1'b1;
              state_d = ST_SYNC;
            end else begin
              state_d = ST_OPERAND;
            end
          end
        end
        ST_OPERAND: begin
          data_d = in_data;
          ov_d   = 1'b1;
          idx_d  = nxt_q;
          nxt_d  = nxt_q + 5'd1;
          rem_d  = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            done_d  = 1'b1;
            state_d = ST_SYNC;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SYNC;
      fields_q <= '0;
      rem_q    <= '0;
      nxt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      opv_q    <= 1'b0;
      ov_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      rem_q    <= rem_d;
      nxt_q    <= nxt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      opv_q    <= opv_d;
      ov_q     <= ov_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign in_ready      = ~rst;
  assign instruction   = fields_q.instr;
  assign size_a        = fields_q.size_a;
  assign size_b        = fields_q.size_b;
  assign ptr           = fields_q.ptr;
  assign cs_addr       = fields_q.cs_addr;
  assign sib           = fields_q.sib;
  assign size_c        = fields_q.size_c;
  assign opcode_valid  = opv_q;
  assign operand_data  = data_q;
  assign operand_valid = ov_q;
  assign operand_index = idx_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
